cpu_acc_gen: RTL and testbench



---
 rtl/cpu_acc_gen_if.sv | 24 ++
 rtl/cpu_acc_gen.sv | 181 ++++++++++++++++++
 tb/tb_cpu_acc_gen.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_acc_gen_if.sv
// Host/IO bundle for cpu_acc_gen: start control, RAM load port, switches, display and debug status.
interface cpu_acc_gen_if #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [WORD_W-1:0] switches;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [WORD_W-1:0] prog_data;
  logic [WORD_W-1:0] display;
  logic              halted;
  logic [ADDR_W-1:0] pc;

  modport master (
    output start, switches, prog_we, prog_addr, prog_data,
    input  display, halted, pc
  );

  modport slave (
    input  start, switches, prog_we, prog_addr, prog_data,
    output display, halted, pc
  );
endinterface

// File: rtl/cpu_acc_gen.sv
// Multicycle accumulator CPU with internal program/data RAM and host load port.
// Optional macro CPU_SAT_EN: ADD/SUB saturate as unsigned instead of wrapping.
module cpu_acc_gen #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3,
  parameter int ADDR_W = WORD_W - OP_W
) (
  input  logic           clock,
  input  logic           reset,
  cpu_acc_gen_if.slave   bus
);

  generate
    if (OP_W != 3) begin : g_op_w_check
      $error("cpu_acc_gen: OP_W must be 3 for this opcode map");
    end
    if (WORD_W < OP_W + 2) begin : g_word_w_check
      $error("cpu_acc_gen: WORD_W must be at least OP_W+2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4
  } state_t;

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BNZ   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_IN    = OP_W'(5);
  localparam logic [OP_W-1:0] OP_OUT   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);

  localparam int DEPTH = 1 << ADDR_W;

  function automatic logic [WORD_W-1:0] f_add(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b);
`ifdef CPU_SAT_EN
    logic [WORD_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    f_add = s[WORD_W] ? {WORD_W{1'b1}} : s[WORD_W-1:0];
`else
    f_add = a + b;
`endif
  endfunction

  function automatic logic [WORD_W-1:0] f_sub(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b);
`ifdef CPU_SAT_EN
    logic [WORD_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    f_sub = d[WORD_W] ? {WORD_W{1'b0}} : d[WORD_W-1:0];
`else
    f_sub = a - b;
`endif
  endfunction

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [WORD_W-1:0] r_acc;
  logic [WORD_W-1:0] r_ir;
  logic [WORD_W-1:0] r_display;
  logic              r_halted;
  logic [WORD_W-1:0] r_rdata;
  logic [WORD_W-1:0] r_mem [0:DEPTH-1];
  logic              r_wb_valid;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [WORD_W-1:0] r_wb_data;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [WORD_W-1:0] w_acc_nxt;
  logic [WORD_W-1:0] w_ir_nxt;
  logic [WORD_W-1:0] w_display_nxt;
  logic              w_store;
  logic [OP_W-1:0]   w_op;
  logic [ADDR_W-1:0] w_opnd;
  logic [ADDR_W-1:0] w_raddr;

  assign w_op    = r_ir[WORD_W-1:ADDR_W];
  assign w_opnd  = r_ir[ADDR_W-1:0];
  assign w_raddr = (r_state == S_EXEC) ? w_opnd : r_pc;

  // Next-state and datapath decode for the HALT/FETCH/DECODE/EXEC/MEM sequence.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_acc_nxt     = r_acc;
    w_ir_nxt      = r_ir;
    w_display_nxt = r_display;
    w_store       = 1'b0;
    case (r_state)
      S_HALT: begin
        if (bus.start) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = {ADDR_W{1'b0}};
        end else begin
          w_state_nxt = S_HALT;
        end
      end
      S_FETCH: w_state_nxt = S_DECODE;
      S_DECODE: begin
        w_ir_nxt    = r_rdata;
        w_pc_nxt    = r_pc + ADDR_W'(1'b1);
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_state_nxt = S_FETCH;
        case (w_op)
          OP_LOAD, OP_ADD, OP_SUB: w_state_nxt = S_MEM;
          OP_STORE: w_store = 1'b1;
          OP_BNZ: begin
            if (r_acc != {WORD_W{1'b0}}) begin
              w_pc_nxt = w_opnd;
            end else begin
              w_pc_nxt = r_pc;
            end
          end
          OP_IN:   w_acc_nxt     = bus.switches;
          OP_OUT:  w_display_nxt = r_acc;
          OP_HALT: w_state_nxt   = S_HALT;
          default: w_state_nxt   = S_HALT;
        endcase
      end
      S_MEM: begin
        w_state_nxt = S_FETCH;
        case (w_op)
          OP_LOAD: w_acc_nxt = r_rdata;
          OP_ADD:  w_acc_nxt = f_add(r_acc, r_rdata);
          OP_SUB:  w_acc_nxt = f_sub(r_acc, r_rdata);
          default: w_acc_nxt = r_acc;
        endcase
      end
      default: w_state_nxt = S_HALT;
    endcase
  end

  // Architectural registers and the one-deep posted host-write buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_HALT;
      r_pc       <= {ADDR_W{1'b0}};
      r_acc      <= {WORD_W{1'b0}};
      r_ir       <= {WORD_W{1'b0}};
      r_display  <= {WORD_W{1'b0}};
      r_halted   <= 1'b1;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= {ADDR_W{1'b0}};
      r_wb_data  <= {WORD_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_acc      <= w_acc_nxt;
      r_ir       <= w_ir_nxt;
      r_display  <= w_display_nxt;
      r_halted   <= (w_state_nxt == S_HALT);
      r_wb_valid <= (r_state == S_HALT) && bus.prog_we;
      r_wb_addr  <= bus.prog_addr;
      r_wb_data  <= bus.prog_data;
    end
  end

  // Host writes land one cycle late, so a start issued with a write to address 0
  // fetches the previous word there (read-before-write on the same edge).
  always_ff @(posedge clock) begin
    if (r_wb_valid) begin
      r_mem[r_wb_addr] <= r_wb_data;
    end else if (w_store) begin
      r_mem[w_opnd] <= r_acc;
    end
    r_rdata <= r_mem[w_raddr];
  end

  assign bus.display = r_display;
  assign bus.halted  = r_halted;
  assign bus.pc      = r_pc;

endmodule

// File: tb/tb_cpu_acc_gen.sv
// Self-checking bench for cpu_acc_gen: directed scenarios plus random programs vs an ISA-level model.
module tb_cpu_acc_gen;
  logic clock = 1'b0;
  logic reset = 1'b1;

  cpu_acc_gen_if #(.WORD_W(8), .ADDR_W(5)) bus ();
  cpu_acc_gen dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Instruction-level reference state
  logic [7:0] m_mem [32];
  logic [7:0] m_acc;
  logic [7:0] m_disp;
  logic [7:0] m_sw;
  logic [4:0] m_pc;
  int         m_cycles;
  logic [7:0] m_outs [$];
  logic [7:0] seen_q [$];
  int         last_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Executes the program one instruction at a time; 4 cycles for memory-reading ops, 3 otherwise.
  task automatic model_run(input int cap, output bit ok);
    logic [7:0] ins;
    logic [4:0] a;
    int v;
    ok = 1'b0;
    m_pc = 5'd0;
    m_cycles = 0;
    m_outs.delete();
    for (int s = 0; s < cap && !ok; s++) begin
      ins  = m_mem[m_pc];
      a    = ins[4:0];
      m_pc = m_pc + 5'd1;
      case (ins[7:5])
        3'd0: begin m_acc = m_mem[a]; m_cycles += 4; end
        3'd1: begin m_mem[a] = m_acc; m_cycles += 3; end
        3'd2, 3'd3: begin
          if (ins[7:5] == 3'd2) v = int'(m_acc) + int'(m_mem[a]);
          else v = int'(m_acc) - int'(m_mem[a]);
`ifdef CPU_SAT_EN
          if (v > 255) v = 255;
          else if (v < 0) v = 0;
`else
          v = (v + 256) % 256;
`endif
          m_acc = v[7:0];
          m_cycles += 4;
        end
        3'd4: begin if (m_acc != 8'd0) m_pc = a; m_cycles += 3; end
        3'd5: begin m_acc = m_sw; m_cycles += 3; end
        3'd6: begin
          if (m_acc != m_disp) m_outs.push_back(m_acc);
          m_disp = m_acc;
          m_cycles += 3;
        end
        default: begin m_cycles += 3; ok = 1'b1; end
      endcase
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d, input bit mirror);
    if (mirror) m_mem[a] = d;
    bus.prog_we = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    @(posedge clock); #1;
    bus.prog_we = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input int inject_at);
    logic [7:0] prev;
    int n;
    seen_q.delete();
    prev = bus.display;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    n = 0;
    while (bus.halted !== 1'b1 && n < m_cycles + 20) begin
      if (n == inject_at) begin
        bus.prog_we = 1'b1; bus.prog_addr = 5'd20; bus.prog_data = 8'h55; bus.start = 1'b1;
      end
      @(posedge clock); #1;
      bus.prog_we = 1'b0;
      bus.start = 1'b0;
      n++;
      if (bus.display !== prev) begin
        seen_q.push_back(bus.display);
        prev = bus.display;
      end
    end
    last_n = n;
    check({tag, ".cycles"}, n, m_cycles);
    check({tag, ".halted"}, bus.halted, 1);
    check({tag, ".pc"}, bus.pc, m_pc);
    check({tag, ".display"}, bus.display, m_disp);
    check({tag, ".acc"}, dut.r_acc, m_acc);
    check({tag, ".nouts"}, seen_q.size(), m_outs.size());
    for (int i = 0; i < seen_q.size() && i < m_outs.size(); i++)
      check($sformatf("%s.out%0d", tag, i), seen_q[i], m_outs[i]);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s.mem%0d", tag, i), dut.r_mem[i], m_mem[i]);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    logic [7:0] cand [32];
    logic [7:0] sv_mem [32];
    logic [7:0] sv_acc, sv_disp;

    bus.start = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = 5'd0;
    bus.prog_data = 8'd0; bus.switches = 8'd0;
    m_acc = 8'd0; m_disp = 8'd0; m_sw = 8'd0;

    // Reset state
    #12;
    check("rst.display", bus.display, 8'h00);
    check("rst.halted", bus.halted, 1);
    check("rst.pc", bus.pc, 5'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) wr(i[4:0], 8'h00, 1'b1);

    // Scenario 1: IN, OUT, HALT
    wr(5'd0, 8'hA0, 1'b1); wr(5'd1, 8'hC0, 1'b1); wr(5'd2, 8'hE0, 1'b1);
    bus.switches = 8'h05; m_sw = 8'h05;
    model_run(100, ok);
    run_and_check("s1", -1);
    check("s1.const_display", bus.display, 8'h05);
    check("s1.const_cycles", last_n, 9);
    check("s1.const_pc", bus.pc, 5'd3);

    // Scenario 2: LOAD/ADD/STORE/OUT with carry out
    wr(5'd0, 8'h10, 1'b1); wr(5'd1, 8'h51, 1'b1); wr(5'd2, 8'h32, 1'b1);
    wr(5'd3, 8'hC0, 1'b1); wr(5'd4, 8'hE0, 1'b1);
    wr(5'd16, 8'hF0, 1'b1); wr(5'd17, 8'h20, 1'b1);
    model_run(100, ok);
    run_and_check("s2", -1);
`ifdef CPU_SAT_EN
    check("s2.const_display", bus.display, 8'hFF);
    check("s2.const_m18", dut.r_mem[18], 8'hFF);
`else
    check("s2.const_display", bus.display, 8'h10);
    check("s2.const_m18", dut.r_mem[18], 8'h10);
`endif

    // pc wraps 31 -> 0 (ACC nonzero from previous run)
    wr(5'd0, 8'h9E, 1'b1); wr(5'd1, 8'hE0, 1'b1); wr(5'd29, 8'h00, 1'b1);
    wr(5'd30, 8'h1D, 1'b1); wr(5'd31, 8'hC0, 1'b1);
    model_run(100, ok);
    run_and_check("wrap", -1);
    check("wrap.const_pc", bus.pc, 5'd2);
    check("wrap.const_cycles", last_n, 16);

    // Scenario 6: asynchronous reset in MEM of ADD
    wr(5'd0, 8'h10, 1'b1); wr(5'd1, 8'h51, 1'b1); wr(5'd2, 8'h32, 1'b1);
    wr(5'd3, 8'hC0, 1'b1); wr(5'd4, 8'hE0, 1'b1);
    wr(5'd16, 8'h21, 1'b1); wr(5'd17, 8'h13, 1'b1); wr(5'd18, 8'h77, 1'b1);
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (7) begin @(posedge clock); #1; end
    check("s6.pre_halted", bus.halted, 0);
    #2 reset = 1'b1;
    #1;
    check("s6.halted", bus.halted, 1);
    check("s6.display", bus.display, 8'h00);
    check("s6.pc", bus.pc, 5'd0);
    @(posedge clock); #1;
    check("s6.m18", dut.r_mem[18], 8'h77);
    reset = 1'b0;
    m_acc = 8'd0; m_disp = 8'd0;
    model_run(100, ok);
    run_and_check("s6.rerun", -1);
    check("s6.const_display", bus.display, 8'h34);

    // Scenario 3: countdown loop
    wr(5'd0, 8'h14, 1'b1); wr(5'd1, 8'h75, 1'b1); wr(5'd2, 8'h34, 1'b1);
    wr(5'd3, 8'hC0, 1'b1); wr(5'd4, 8'h81, 1'b1); wr(5'd5, 8'hE0, 1'b1);
    wr(5'd20, 8'd3, 1'b1); wr(5'd21, 8'd1, 1'b1);
    model_run(100, ok);
    run_and_check("s3", -1);
    check("s3.const_nouts", seen_q.size(), 3);
    for (int i = 0; i < 3 && i < seen_q.size(); i++)
      check($sformatf("s3.const_out%0d", i), seen_q[i], 2 - i);
    check("s3.const_m20", dut.r_mem[20], 8'h00);

    // Scenario 5: host write and start during the run are ignored
    wr(5'd20, 8'd3, 1'b1);
    model_run(100, ok);
    run_and_check("s5", 10);
    check("s5.const_nouts", seen_q.size(), 3);
    check("s5.const_m20", dut.r_mem[20], 8'h00);

    // Scenario 4: SUB underflow
    wr(5'd0, 8'h10, 1'b1); wr(5'd1, 8'h71, 1'b1); wr(5'd2, 8'hC0, 1'b1);
    wr(5'd3, 8'hE0, 1'b1); wr(5'd16, 8'h01, 1'b1); wr(5'd17, 8'h02, 1'b1);
    model_run(100, ok);
    run_and_check("s4", -1);
`ifdef CPU_SAT_EN
    check("s4.const_display", bus.display, 8'h00);
`else
    check("s4.const_display", bus.display, 8'hFF);
`endif

    // Start together with a host write to address 0: old word (HALT) is fetched
    wr(5'd0, 8'hE0, 1'b1); wr(5'd1, 8'hC0, 1'b1); wr(5'd2, 8'hE0, 1'b1);
    bus.prog_we = 1'b1; bus.prog_addr = 5'd0; bus.prog_data = 8'hA0; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.prog_we = 1'b0; bus.start = 1'b0;
    n = 0;
    while (bus.halted !== 1'b1 && n < 30) begin
      @(posedge clock); #1;
      n++;
    end
    check("same.cycles", n, 3);
    check("same.pc", bus.pc, 5'd1);
    m_mem[0] = 8'hA0;
    check("same.m0", dut.r_mem[0], 8'hA0);
    bus.switches = 8'h3C; m_sw = 8'h3C;
    model_run(100, ok);
    run_and_check("same.rerun", -1);
    check("same.const_display", bus.display, 8'h3C);

    // Random programs that halt within the model's step cap
    for (int r = 0; r < 12; r++) begin
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
        for (int i = 0; i < 32; i++) cand[i] = 8'($urandom_range(0, 255));
        sv_mem = m_mem; sv_acc = m_acc; sv_disp = m_disp;
        m_sw = 8'($urandom_range(0, 255));
        m_mem = cand;
        model_run(200, ok);
        if (!ok) begin
          m_mem = sv_mem; m_acc = sv_acc; m_disp = sv_disp;
        end
      end
      if (ok) begin
        bus.switches = m_sw;
        for (int i = 0; i < 32; i++) wr(i[4:0], cand[i], 1'b0);
        run_and_check($sformatf("rnd%0d", r), -1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
